// File: rtl/mem_arb_pkg.sv
// Shared encodings and types for the instruction/data RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned CMD_W = 2;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned N_REQ = 3;
  localparam int unsigned CNT_W = 16;

  localparam logic [CMD_W-1:0] M_NONE  = 2'b00;
  localparam logic [CMD_W-1:0] M_READ  = 2'b01;
  localparam logic [CMD_W-1:0] M_WRITE = 2'b10;

  localparam logic [ID_W-1:0] REQ_F = 2'd0;
  localparam logic [ID_W-1:0] REQ_D = 2'd1;
  localparam logic [ID_W-1:0] REQ_X = 2'd2;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } ret_tag_t;

  // Round-robin successor: F -> D -> X -> F.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == REQ_X) ? REQ_F : ID_W'(id + 1'b1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, RAM and status signals of the memory arbiter; slave = arbiter side.
interface mem_arbiter_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 16
);
  import mem_arb_pkg::*;

  logic             halt;
  logic             f_req, d_req, x_req;
  logic [AW-1:0]    f_addr, d_addr, x_addr;
  logic             d_we, x_we;
  logic [DW-1:0]    d_wdata, x_wdata;
  logic             f_gnt, d_gnt, x_gnt;
  logic             f_rvalid, d_rvalid, x_rvalid;
  logic [DW-1:0]    rdata;
  logic [CMD_W-1:0] mem_cmd;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  halt, f_req, d_req, x_req, f_addr, d_addr, x_addr,
           d_we, x_we, d_wdata, x_wdata, mem_rdata,
    output f_gnt, d_gnt, x_gnt, f_rvalid, d_rvalid, x_rvalid, rdata,
           mem_cmd, mem_addr, mem_wdata, stall_cnt
  );

  modport master (
    output halt, f_req, d_req, x_req, f_addr, d_addr, x_addr,
           d_we, x_we, d_wdata, x_wdata, mem_rdata,
    input  f_gnt, d_gnt, x_gnt, f_rvalid, d_rvalid, x_rvalid, rdata,
           mem_cmd, mem_addr, mem_wdata, stall_cnt
  );

endinterface

// File: rtl/mem_arbiter_rr_arb3.sv
// Three-way round-robin pick; searching starts after the last granted requester.
module rr_arb3
  import mem_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_elig,
  input  logic [ID_W-1:0]  i_last,
  output logic [N_REQ-1:0] o_gnt_c,
  output logic [ID_W-1:0]  o_id_c,
  output logic             o_any_c
);

  logic [ID_W-1:0] w_cand;

  always_comb begin
    o_gnt_c = '0;
    o_id_c  = REQ_F;
    o_any_c = 1'b0;
    w_cand  = next_id(i_last);
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!o_any_c && i_elig[w_cand]) begin
        o_gnt_c[w_cand] = 1'b1;
        o_id_c          = w_cand;
        o_any_c         = 1'b1;
      end
      w_cand = next_id(w_cand);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for fetch (F), data (D) and loader (X) requesters,
// with an in-order read-return pipeline and a saturating stall counter.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW     = 9,
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = 1
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_id;
  logic             w_any;
  logic [ID_W-1:0]  r_last;
  logic [CMD_W-1:0] w_cmd;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_wdata;
  ret_tag_t         w_push;
  ret_tag_t         w_head;
  ret_tag_t         r_pipe [RD_LAT];
  logic [1:0]       w_n_elig;
  logic [CNT_W-1:0] r_stall_cnt;

  // A halted fetch is simply not a candidate.
  assign w_elig = {bus.x_req, bus.d_req, bus.f_req & ~bus.halt};

  rr_arb3 u_rr (
    .i_elig  (w_elig),
    .i_last  (r_last),
    .o_gnt_c (w_gnt),
    .o_id_c  (w_id),
    .o_any_c (w_any)
  );

  assign bus.f_gnt = w_gnt[REQ_F];
  assign bus.d_gnt = w_gnt[REQ_D];
  assign bus.x_gnt = w_gnt[REQ_X];

  always_comb begin
    w_cmd   = M_NONE;
    w_addr  = '0;
    w_wdata = '0;
    if (w_any) begin
      case (w_id)
        REQ_D: begin
          w_cmd   = bus.d_we ? M_WRITE : M_READ;
          w_addr  = bus.d_addr;
          w_wdata = bus.d_we ? bus.d_wdata : '0;
        end
        REQ_X: begin
          w_cmd   = bus.x_we ? M_WRITE : M_READ;
          w_addr  = bus.x_addr;
          w_wdata = bus.x_we ? bus.x_wdata : '0;
        end
        default: begin
          w_cmd  = M_READ;
          w_addr = bus.f_addr;
        end
      endcase
    end
  end

  assign bus.mem_cmd   = w_cmd;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = w_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last <= REQ_X;
    end else if (w_any) begin
      r_last <= w_id;
    end
  end

  assign w_push.valid = (w_cmd == M_READ);
  assign w_push.id    = (w_cmd == M_READ) ? w_id : REQ_F;

  // Return pipeline: one tag per cycle so returns stay in grant order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= w_push;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign w_head       = r_pipe[RD_LAT-1];
  assign bus.f_rvalid = w_head.valid && (w_head.id == REQ_F);
  assign bus.d_rvalid = w_head.valid && (w_head.id == REQ_D);
  assign bus.x_rvalid = w_head.valid && (w_head.id == REQ_X);
  assign bus.rdata    = bus.mem_rdata;

  assign w_n_elig = 2'(w_elig[0]) + 2'(w_elig[1]) + 2'(w_elig[2]);

  // At most one grant per cycle, so a stall is any cycle with more eligible than granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if ((w_n_elig > 2'(w_any)) && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port instruction/data RAM between three requesters: instruction fetch (F), load/store data access (D) and the debug/program loader (X). Each cycle it grants at most one access round-robin, drives the RAM command/address/write-data bus, and routes read data back with a per-requester valid strobe after the fixed RAM read latency. It sits between the CPU controller/datapath and the RAM, and replaces direct `addr_sel`/`mem_cmd` steering.

## Interface
Parameters:
- `AW`, 9: RAM address width.
- `DW`, 16: RAM data width.
- `RD_LAT`, 1: RAM read latency in cycles. Legal range is 1..4.

Ports:
- `clk` in 1: single clock. All state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `halt` in 1: when 1, `f_req` is masked and never granted.
- `f_req`, `d_req`, `x_req` in 1 each: access request. Hold until granted.
- `f_addr`, `d_addr`, `x_addr` in AW each: access address. Hold stable while `*_req` = 1.
- `d_we`, `x_we` in 1 each: 1 = write, 0 = read. F is read-only.
- `d_wdata`, `x_wdata` in DW each: write data. Hold stable while `*_req` = 1.
- `f_gnt`, `d_gnt`, `x_gnt` out 1 each: access accepted this cycle. Combinational.
- `f_rvalid`, `d_rvalid`, `x_rvalid` out 1 each: `rdata` belongs to that requester this cycle.
- `rdata` out DW: equal to `mem_rdata`, broadcast to all requesters.
- `mem_cmd` out 2: RAM command, from the shared encodings NONE = 00, READ = 01, WRITE = 10.
- `mem_addr` out AW: RAM address.
- `mem_wdata` out DW: RAM write data.
- `mem_rdata` in DW: RAM read data.
- `stall_cnt` out 16: saturating count of cycles in which at least one eligible request was not granted.

## Operation
- A requester is eligible when its `*_req` = 1. For F, eligibility also requires `halt` = 0.
- Exactly one eligible requester is granted per cycle. With none eligible, all grants are 0 and `mem_cmd` = NONE.
- Round-robin order is F → D → X → F.
- Search starts at the requester after `last`, the most recently granted one. `last` updates only on a grant.
- In the grant cycle:
  - `mem_cmd` = READ if `we` = 0, else WRITE.
  - `mem_addr` and `mem_wdata` come from the granted requester. `mem_wdata` = 0 for F and for reads.
- Writes complete at the grant edge and produce no `rvalid`.
- Reads push {valid = 1, id} into an RD_LAT-deep return pipeline. Every other cycle pushes {valid = 0}.
- The pipeline head asserts the matching `*_rvalid` for exactly one cycle.
- Returns come back in grant order, with no reordering. Back-to-back reads give back-to-back `rvalid`s.
- Setting `halt` does not cancel fetch reads already in flight; they still return.
- `stall_cnt` increments when (eligible count) > (grant count) and holds at 0xFFFF.
- Protocol error: a requester deasserting `req` before its grant is treated as a withdrawn request and is not flagged.

## Timing
- Reset (`reset` = 0, asynchronous):
  - `last` = X, so F has top priority after reset.
  - Return pipeline cleared, so in-flight reads are dropped and no `rvalid` follows.
  - `stall_cnt` = 0.
- The comb outputs `gnt`/`mem_*` are 0/NONE while all `req` are 0. Since all `req` are 0 during reset, every output is 0/NONE in reset.
- Grant latency: the same cycle the request is seen, if it wins. Worst-case wait under full contention is 2 cycles.
- Read data: `*_rvalid` is high exactly RD_LAT cycles after the `*_gnt` cycle. `rdata` is valid in that same cycle.
- A requester may assert a new request in the cycle after its grant, without waiting for `rvalid`.
- Write then read of the same address in consecutive grants returns the new data. The arbiter issues in grant order and the RAM has a single port.
- Reset release mid-sequence: arbitration restarts with the F-first order on the first edge after deassertion.

## Structure
- Package `mem_arb_pkg` holds:
  - `M_NONE`, `M_READ`, `M_WRITE` (2-bit).
  - Requester IDs `REQ_F` = 0, `REQ_D` = 1, `REQ_X` = 2 (2-bit).
  - Type `ret_tag_t` = {valid, id}.
- Sub-module `rr_arb3`:
  - Inputs: 3-bit eligible vector and `last`.
  - Outputs: one-hot grant and granted id.
  - Combinational, except the `last` register, which lives in `mem_arbiter`.
- `mem_arbiter` contains the return pipeline (shift register of `ret_tag_t`), the command/address muxes and `stall_cnt`.

## Test plan
- **Post-reset priority.** Release reset, then hold `f_req`, `d_req`, `x_req` = 1 with reads to 0x010 / 0x020 / 0x030 for 6 cycles.
  - Grants go F, D, X, F, D, X.
  - `mem_addr` follows 0x010, 0x020, 0x030, …
  - `stall_cnt` = 6.
- **Read latency sweep.** For RD_LAT = 1, 2 and 4, RAM preloaded with 0x1234 at 0x005, issue a D read of 0x005.
  - `d_rvalid` = 1 exactly RD_LAT cycles after `d_gnt`, with `rdata` = 0x1234.
  - No other `rvalid` fires.
- **Write/read ordering.** D writes 0xBEEF to 0x040, then X reads 0x040 on the next cycle.
  - `mem_cmd` sequence is WRITE, READ.
  - `x_rvalid` returns 0xBEEF and `d_rvalid` stays 0.
- **Halt masking.** F read granted at cycle t, then `halt` = 1 at t+1 with `f_req` held high and D idle.
  - The in-flight `f_rvalid` still appears at t+RD_LAT.
  - No further `f_gnt`; `mem_cmd` = NONE.
  - `stall_cnt` stays unchanged, since masked F is not eligible.
- **Reset mid-read.** With RD_LAT = 3, grant an F read, then pulse `reset` low 1 cycle later.
  - No `f_rvalid` ever appears.
  - All outputs are 0/NONE.
  - The next grant goes to F.
- **Counter saturation.** Force `stall_cnt` near its limit by holding F and D requesting for 65 540 cycles.
  - `stall_cnt` stops at 0xFFFF and does not wrap.
